// File: rtl/hms_mode_ctrl.sv
// Mode/sequencing controller for the HMS clock: button debounce, CLOCK/SETUP FSM,
// counter enable pulses, blink mask and decimal points. Everything registered.
module hms_mode_ctrl #(
    parameter int DEB_CYC   = 500000,
    parameter int TICK_CYC  = 50000000,
    parameter int BLINK_CYC = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw_mode,
    input  logic       i_sw_pos,
    input  logic       i_sw_inc,
    input  logic       i_sec_max,
    input  logic       i_min_max,
    output logic       o_mode,
    output logic [1:0] o_position,
    output logic       o_sec_en,
    output logic       o_min_en,
    output logic       o_hour_en,
    output logic [5:0] o_blink_mask,
    output logic [5:0] o_six_dp
);

    localparam int DEB_W   = $clog2(DEB_CYC + 1);
    localparam int TICK_W  = $clog2(TICK_CYC + 1);
    localparam int BLINK_W = $clog2(BLINK_CYC + 1);

    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;

    typedef enum logic {ST_CLOCK = 1'b0, ST_SETUP = 1'b1} state_t;

    // Button index: 0 = mode, 1 = pos, 2 = inc
    logic [2:0]       raw;
    logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]       acc_q, acc_d, acc_dly_q, acc_dly_d;
    logic [2:0]       press_q, press_d;
    logic [DEB_W-1:0] deb_cnt_q [3];
    logic [DEB_W-1:0] deb_cnt_d [3];

    state_t             state_q, state_d;
    logic [1:0]         pos_q, pos_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_hide_q, blink_hide_d;
    logic               sec_en_q, sec_en_d, min_en_q, min_en_d, hour_en_q, hour_en_d;
    logic [5:0]         mask_q, mask_d, dp_q, dp_d;

    logic tick, mode_evt, pos_evt, inc_evt, blink_restart;

    assign raw = {i_sw_inc, i_sw_pos, i_sw_mode};

    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        acc_d     = acc_q;
        acc_dly_d = acc_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != acc_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEB_CYC - 1)) acc_d[i] = sync2_q[i];
                else deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
        // Press is the registered falling edge of the accepted level
        press_d = acc_dly_q & ~acc_q;
    end

    assign mode_evt = press_q[0];
    assign pos_evt  = press_q[1];
    assign inc_evt  = press_q[2];
    assign tick     = (tick_cnt_q == TICK_W'(TICK_CYC - 1));

    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        sec_en_d      = 1'b0;
        min_en_d      = 1'b0;
        hour_en_d     = 1'b0;
        blink_restart = 1'b0;
        case (state_q)
            ST_CLOCK: begin
                sec_en_d  = tick;
                min_en_d  = tick & i_sec_max;
                hour_en_d = tick & i_sec_max & i_min_max;
                if (mode_evt) begin
                    state_d       = ST_SETUP;
                    pos_d         = POS_SEC;
                    blink_restart = 1'b1;
                end
            end
            ST_SETUP: begin
                if (mode_evt) begin
                    state_d = ST_CLOCK;
                end else begin
                    // inc acts on the current position before pos advances it
                    if (inc_evt) begin
                        sec_en_d      = (pos_q == POS_SEC);
                        min_en_d      = (pos_q == POS_MIN);
                        hour_en_d     = (pos_q == POS_HOUR);
                        blink_restart = 1'b1;
                    end
                    if (pos_evt) begin
                        pos_d         = (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
                        blink_restart = 1'b1;
                    end
                end
            end
        endcase

        // Cleared on SETUP entry and held there, so the first second after exit is full
        if (state_q == ST_CLOCK && state_d == ST_CLOCK)
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        else
            tick_cnt_d = '0;

        if (state_d != ST_SETUP || blink_restart) begin
            blink_cnt_d  = '0;
            blink_hide_d = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_CYC - 1)) begin
            blink_cnt_d  = '0;
            blink_hide_d = ~blink_hide_q;
        end else begin
            blink_cnt_d  = blink_cnt_q + BLINK_W'(1);
            blink_hide_d = blink_hide_q;
        end

        mask_d = 6'b000000;
        if (state_d == ST_SETUP && blink_hide_d) begin
            case (pos_d)
                POS_SEC:  mask_d = 6'b000011;
                POS_MIN:  mask_d = 6'b001100;
                POS_HOUR: mask_d = 6'b110000;
                default:  mask_d = 6'b000000;
            endcase
        end

        dp_d = (state_d == ST_CLOCK && tick_cnt_d < TICK_W'(TICK_CYC / 2)) ? 6'b010100 : 6'b000000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 3'b111;
            sync2_q      <= 3'b111;
            acc_q        <= 3'b111;
            acc_dly_q    <= 3'b111;
            press_q      <= 3'b000;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
            state_q      <= ST_CLOCK;
            pos_q        <= POS_SEC;
            tick_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            blink_hide_q <= 1'b0;
            sec_en_q     <= 1'b0;
            min_en_q     <= 1'b0;
            hour_en_q    <= 1'b0;
            mask_q       <= 6'b000000;
            dp_q         <= 6'b010100;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            acc_q        <= acc_d;
            acc_dly_q    <= acc_dly_d;
            press_q      <= press_d;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q      <= state_d;
            pos_q        <= pos_d;
            tick_cnt_q   <= tick_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_hide_q <= blink_hide_d;
            sec_en_q     <= sec_en_d;
            min_en_q     <= min_en_d;
            hour_en_q    <= hour_en_d;
            mask_q       <= mask_d;
            dp_q         <= dp_d;
        end
    end

    assign o_mode       = (state_q == ST_SETUP);
    assign o_position   = pos_q;
    assign o_sec_en     = sec_en_q;
    assign o_min_en     = min_en_q;
    assign o_hour_en    = hour_en_q;
    assign o_blink_mask = mask_q;
    assign o_six_dp     = dp_q;

endmodule

// File: tb/tb_hms_mode_ctrl.sv
// Bench for hms_mode_ctrl with small timing parameters; enable pulses are
// scoreboarded by cycle, levels are checked at chosen cycles.
module tb_hms_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_sw_mode, i_sw_pos, i_sw_inc, i_sec_max, i_min_max;
    logic       o_mode, o_sec_en, o_min_en, o_hour_en;
    logic [1:0] o_position;
    logic [5:0] o_blink_mask, o_six_dp;

    hms_mode_ctrl #(.DEB_CYC(4), .TICK_CYC(10), .BLINK_CYC(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_sw_mode(i_sw_mode), .i_sw_pos(i_sw_pos), .i_sw_inc(i_sw_inc),
        .i_sec_max(i_sec_max), .i_min_max(i_min_max),
        .o_mode(o_mode), .o_position(o_position),
        .o_sec_en(o_sec_en), .o_min_en(o_min_en), .o_hour_en(o_hour_en),
        .o_blink_mask(o_blink_mask), .o_six_dp(o_six_dp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    endtask

    typedef struct {
        int         cyc;
        logic [2:0] en;
    } exp_t;
    exp_t sb[$];
    logic sb_on = 1'b0;

    task automatic push_en(input int at, input logic [2:0] en);
        exp_t e;
        e.cyc = at;
        e.en  = en;
        sb.push_back(e);
    endtask

    logic [2:0] mon_exp;
    int         mon_hit;
    always @(negedge clk) begin
        if (sb_on) begin
            mon_exp = 3'b000;
            mon_hit = -1;
            foreach (sb[i]) if (sb[i].cyc == cyc) mon_hit = i;
            if (mon_hit >= 0) begin
                mon_exp = sb[mon_hit].en;
                sb.delete(mon_hit);
            end
            check_val("en{hour,min,sec}", 32'({o_hour_en, o_min_en, o_sec_en}), 32'(mon_exp));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int r0, b0, p0, e2, p3, q0, r2;

    initial begin
        rst_n = 1'b0;
        i_sw_mode = 1'b1; i_sw_pos = 1'b1; i_sw_inc = 1'b1;
        i_sec_max = 1'b0; i_min_max = 1'b0;
        step(3);
        check_val("rst_mode", 32'(o_mode), 32'd0);
        check_val("rst_pos", 32'(o_position), 32'd0);
        check_val("rst_en", 32'({o_hour_en, o_min_en, o_sec_en}), 32'd0);
        check_val("rst_mask", 32'(o_blink_mask), 32'd0);
        check_val("rst_dp", 32'(o_six_dp), 32'b010100);

        // 1: free-running seconds and colon
        rst_n = 1'b1;
        r0 = cyc;
        sb_on = 1'b1;
        push_en(r0 + 10, 3'b001);
        push_en(r0 + 20, 3'b001);
        push_en(r0 + 30, 3'b001);
        for (int k = 0; k < 30; k++) begin
            check_val("dp_clock", 32'(o_six_dp), (k % 10 < 5) ? 32'b010100 : 32'd0);
            step(1);
        end

        // 2: full carry at a tick
        i_sec_max = 1'b1; i_min_max = 1'b1;
        push_en(r0 + 40, 3'b111);
        step(10);
        i_sec_max = 1'b0; i_min_max = 1'b0;
        push_en(r0 + 50, 3'b001);
        step(1);

        // 3: bounce rejected, then a real mode press
        i_sw_mode = 1'b0; step(3); i_sw_mode = 1'b1; step(7);
        check_val("bounce_mode", 32'(o_mode), 32'd0);
        b0 = cyc;
        i_sw_mode = 1'b0;
        step(6);
        check_val("mode_before", 32'(o_mode), 32'd0);
        step(2);
        check_val("mode_setup", 32'(o_mode), 32'd1);
        check_val("pos_entry", 32'(o_position), 32'd0);
        check_val("dp_setup", 32'(o_six_dp), 32'd0);
        check_val("mask_entry", 32'(o_blink_mask), 32'd0);
        step(2);
        i_sw_mode = 1'b1;
        step(4);
        check_val("mask_sec_hidden", 32'(o_blink_mask), 32'b000011);
        step(10);

        // 4: pos twice, then inc on HOUR; blink restarts on each press
        p0 = cyc;
        i_sw_pos = 1'b0; step(6); i_sw_pos = 1'b1; step(2);
        check_val("pos_min", 32'(o_position), 32'd1);
        step(6);
        i_sw_pos = 1'b0; step(6); i_sw_pos = 1'b1; step(2);
        e2 = cyc;
        check_val("pos_hour", 32'(o_position), 32'd2);
        check_val("mask_vis0", 32'(o_blink_mask), 32'd0);
        step(5);
        check_val("mask_vis5", 32'(o_blink_mask), 32'd0);
        step(1);
        check_val("mask_hid6", 32'(o_blink_mask), 32'b110000);
        step(5);
        check_val("mask_hid11", 32'(o_blink_mask), 32'b110000);
        step(1);
        check_val("mask_vis12", 32'(o_blink_mask), 32'd0);
        step(1);
        p3 = cyc;
        i_sw_inc = 1'b0;
        push_en(p3 + 8, 3'b100);
        step(6); i_sw_inc = 1'b1; step(1);
        check_val("mask_pre_inc", 32'(o_blink_mask), 32'b110000);
        step(1);
        check_val("mask_inc_restart", 32'(o_blink_mask), 32'd0);
        check_val("pos_after_inc", 32'(o_position), 32'd2);
        step(5);
        check_val("mask_inc_vis5", 32'(o_blink_mask), 32'd0);
        step(1);
        check_val("mask_inc_hid6", 32'(o_blink_mask), 32'b110000);
        step(4);

        // 5: wrap to SEC, to MIN, then pos+inc together, then mode+inc together
        i_sw_pos = 1'b0; step(6); i_sw_pos = 1'b1; step(8);
        check_val("pos_wrap", 32'(o_position), 32'd0);
        i_sw_pos = 1'b0; step(6); i_sw_pos = 1'b1; step(8);
        check_val("pos_min2", 32'(o_position), 32'd1);
        push_en(cyc + 8, 3'b010);
        i_sw_pos = 1'b0; i_sw_inc = 1'b0; step(6);
        i_sw_pos = 1'b1; i_sw_inc = 1'b1; step(2);
        check_val("pos_inc_pos", 32'(o_position), 32'd2);
        step(6);
        q0 = cyc;
        push_en(q0 + 18, 3'b001);
        push_en(q0 + 28, 3'b001);
        i_sw_mode = 1'b0; i_sw_inc = 1'b0; step(6);
        i_sw_mode = 1'b1; i_sw_inc = 1'b1; step(2);
        check_val("mode_exit", 32'(o_mode), 32'd0);
        check_val("pos_kept", 32'(o_position), 32'd2);
        check_val("dp_exit", 32'(o_six_dp), 32'b010100);
        check_val("mask_exit", 32'(o_blink_mask), 32'd0);
        step(13);

        // 6: reset in SETUP with a press half-debounced
        i_sw_mode = 1'b0; step(6); i_sw_mode = 1'b1; step(2);
        check_val("mode_setup2", 32'(o_mode), 32'd1);
        step(1);
        i_sw_pos = 1'b0;
        step(3);
        #2;
        rst_n = 1'b0;
        i_sw_pos = 1'b1;
        #1;
        check_val("arst_mode", 32'(o_mode), 32'd0);
        check_val("arst_pos", 32'(o_position), 32'd0);
        check_val("arst_en", 32'({o_hour_en, o_min_en, o_sec_en}), 32'd0);
        check_val("arst_mask", 32'(o_blink_mask), 32'd0);
        check_val("arst_dp", 32'(o_six_dp), 32'b010100);
        step(1);
        rst_n = 1'b1;
        r2 = cyc;
        push_en(r2 + 10, 3'b001);
        push_en(r2 + 20, 3'b001);
        step(25);
        check_val("post_rst_mode", 32'(o_mode), 32'd0);
        check_val("post_rst_pos", 32'(o_position), 32'd0);
        sb_on = 1'b0;
        check_val("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
